// File: rtl/pulse_rx_pkg.sv
// Shared types and constants for the serial pattern receiver and its matching generator.
package pulse_rx_pkg;

   localparam int PULSE_WIDTH_DEFAULT = 8;
   localparam int PULSE_T2_DEFAULT    = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_e;

   // Mid-bit sample position inside a bit time of t2 cycles (floor).
   function automatic int sample_point(input int t2);
      return t2 / 2;
   endfunction

endpackage

// File: rtl/pulse_rx_sync.sv
// Two-flop synchronizer for the serial line plus a registered rising-edge detector.
module pulse_rx_sync
   import pulse_rx_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic serial_i,
   output logic s_o,
   output logic rise_o
);

   logic meta_q;
   logic s_q;
   logic s_dly_q;
   logic rise_q;

   // Synchronizer chain and edge detect on the synchronized value.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q  <= 1'b0;
         s_q     <= 1'b0;
         s_dly_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         meta_q  <= serial_i;
         s_q     <= meta_q;
         s_dly_q <= s_q;
         rise_q  <= s_q & ~s_dly_q;
      end
   end

   assign s_o    = s_q;
   assign rise_o = rise_q;

endmodule

// File: rtl/pulse_pattern_receiver.sv
// Serial pattern receiver: start bit, WIDTH data bits MSB first, low stop bit.
// Optional start-to-start period measurement is enabled by defining PULSE_RX_PERIOD_MEAS_EN.
module pulse_pattern_receiver
   import pulse_rx_pkg::*;
#(
   parameter int WIDTH = PULSE_WIDTH_DEFAULT,
   parameter int T2    = PULSE_T2_DEFAULT,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             signal_in,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             frame_err,
   output logic             busy,
   output logic [CNT_W-1:0] period_out,
   output logic             period_valid
);

   localparam int CW = $clog2(T2);
   localparam int BW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] SAMPLE_PT = CW'(sample_point(T2));
   localparam logic [CW-1:0] BIT_LAST  = CW'(T2 - 1);
   localparam logic [BW-1:0] IDX_LAST  = BW'(WIDTH - 1);

   rx_state_e        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [BW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             dv_q, dv_d;
   logic             fe_q, fe_d;
   logic             busy_q;
   logic             s_s;
   logic             rise_s;
   logic             mid_s;

   pulse_rx_sync u_sync (
      .clk_i    (clk),
      .rst_ni   (reset_n),
      .serial_i (signal_in),
      .s_o      (s_s),
      .rise_o   (rise_s)
   );

   assign mid_s = (cnt_q == SAMPLE_PT);

   // Frame state, bit timing, shift register and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= {CW{1'b0}};
         idx_q   <= {BW{1'b0}};
         shift_q <= {WIDTH{1'b0}};
         data_q  <= {WIDTH{1'b0}};
         dv_q    <= 1'b0;
         fe_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         dv_q    <= dv_d;
         fe_q    <= fe_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   // Next-state logic; the bit counter free-runs modulo T2 while a frame is in progress.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      dv_d    = 1'b0;
      fe_d    = 1'b0;

      if (state_q != IDLE) begin
         cnt_d = (cnt_q == BIT_LAST) ? {CW{1'b0}} : cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end

      case (state_q)
         IDLE: begin
            if (rise_s) begin
               state_d = START;
               cnt_d   = {CW{1'b0}};
               idx_d   = {BW{1'b0}};
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (mid_s) begin
               state_d = s_s ? DATA : IDLE;
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (mid_s) begin
               shift_d = {shift_q[WIDTH-2:0], s_s};
               if (idx_q == IDX_LAST) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + BW'(1);
               end
            end else begin
               state_d = DATA;
            end
         end
         STOP: begin
            // Leaving at the stop midpoint lets a start edge half a bit later be caught.
            if (mid_s) begin
               state_d = IDLE;
               if (!s_s) begin
                  data_d = shift_q;
                  dv_d   = 1'b1;
               end else begin
                  fe_d   = 1'b1;
               end
            end else begin
               state_d = STOP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign data_out   = data_q;
   assign data_valid = dv_q;
   assign frame_err  = fe_q;
   assign busy       = busy_q;

`ifdef PULSE_RX_PERIOD_MEAS_EN
   logic [CNT_W-1:0] per_cnt_q;
   logic [CNT_W-1:0] period_q;
   logic             first_q;
   logic             pv_q;
   logic             accept_s;

   assign accept_s = (state_q == IDLE) && rise_s;

   // Start-to-start period counter, saturating at all-ones.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         per_cnt_q <= {CNT_W{1'b0}};
         period_q  <= {CNT_W{1'b0}};
         first_q   <= 1'b0;
         pv_q      <= 1'b0;
      end else begin
         pv_q <= 1'b0;
         if (accept_s) begin
            if (first_q) begin
               period_q <= (per_cnt_q == {CNT_W{1'b1}}) ? per_cnt_q : per_cnt_q + CNT_W'(1);
               pv_q     <= 1'b1;
            end else begin
               period_q <= period_q;
            end
            per_cnt_q <= {CNT_W{1'b0}};
            first_q   <= 1'b1;
         end else if (per_cnt_q != {CNT_W{1'b1}}) begin
            per_cnt_q <= per_cnt_q + CNT_W'(1);
         end else begin
            per_cnt_q <= per_cnt_q;
         end
      end
   end

   assign period_out   = period_q;
   assign period_valid = pv_q;
`else
   assign period_out   = {CNT_W{1'b0}};
   assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_pattern_receiver.sv
// Self-checking bench for pulse_pattern_receiver: directed scenarios plus random frames
// scored against an event-level model (expected pattern, latency, period per frame).
module tb_pulse_pattern_receiver;

   localparam int W     = 8;
   localparam int T2    = 9;
   localparam int CNT_W = 32;
   localparam int LAT   = 2 + 1 + (1 + W) * T2 + T2 / 2 + 1;
`ifdef PULSE_RX_PERIOD_MEAS_EN
   localparam bit PERIOD_EN = 1'b1;
`else
   localparam bit PERIOD_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset_n;
   logic             signal_in;
   logic [W-1:0]     data_out;
   logic             data_valid;
   logic             frame_err;
   logic             busy;
   logic [CNT_W-1:0] period_out;
   logic             period_valid;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int         obs_dv_t[$];
   logic [7:0] obs_dv_d[$];
   int         obs_fe_t[$];
   logic [31:0] obs_pv_d[$];
   int         exp_dv_t[$];
   logic [7:0] exp_dv_d[$];
   int         exp_fe_t[$];
   logic [31:0] exp_pv_d[$];

   logic [7:0] last_good = 8'h00;
   bit         have_first = 1'b0;
   int         last_start = 0;
   logic       prev_dv = 1'b0;
   logic       prev_fe = 1'b0;

   pulse_pattern_receiver #(.WIDTH(W), .T2(T2), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .signal_in    (signal_in),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .frame_err    (frame_err),
      .busy         (busy),
      .period_out   (period_out),
      .period_valid (period_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Output event recorder and pulse exclusivity / single-cycle monitor.
   always @(negedge clk) begin
      if (data_valid === 1'b1) begin
         obs_dv_t.push_back(cyc);
         obs_dv_d.push_back(data_out);
      end
      if (frame_err === 1'b1) obs_fe_t.push_back(cyc);
      if (period_valid === 1'b1) obs_pv_d.push_back(period_out);
      if (data_valid === 1'b1 || frame_err === 1'b1) begin
         chk("pulse_excl", {63'd0, data_valid & frame_err}, 64'd0);
         chk("pulse_width", {63'd0, (data_valid & prev_dv) | (frame_err & prev_fe)}, 64'd0);
      end
      prev_dv <= data_valid;
      prev_fe <= frame_err;
   end

   task automatic note_start();
      if (PERIOD_EN && have_first) exp_pv_d.push_back(32'(cyc - last_start));
      last_start = cyc;
      have_first = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] pat, input bit stop_hi, input int gap);
      logic [9:0] f;
      f = {1'b1, pat, stop_hi};
      note_start();
      if (!stop_hi) begin
         exp_dv_t.push_back(cyc + LAT);
         exp_dv_d.push_back(pat);
         last_good = pat;
      end else begin
         exp_fe_t.push_back(cyc + LAT);
      end
      for (int i = 9; i >= 0; i--) begin
         signal_in = f[i];
         repeat (T2) @(negedge clk);
      end
      signal_in = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic check_events(input string tag);
      repeat (10) @(negedge clk);
      chk({tag, "_dv_count"}, 64'(obs_dv_t.size()), 64'(exp_dv_t.size()));
      for (int i = 0; i < obs_dv_t.size() && i < exp_dv_t.size(); i++) begin
         chk({tag, "_dv_data"}, 64'(obs_dv_d[i]), 64'(exp_dv_d[i]));
         chk({tag, "_dv_latency_ok"},
             64'((obs_dv_t[i] >= exp_dv_t[i] - 1) && (obs_dv_t[i] <= exp_dv_t[i] + 1)), 64'd1);
      end
      chk({tag, "_fe_count"}, 64'(obs_fe_t.size()), 64'(exp_fe_t.size()));
      for (int i = 0; i < obs_fe_t.size() && i < exp_fe_t.size(); i++) begin
         chk({tag, "_fe_latency_ok"},
             64'((obs_fe_t[i] >= exp_fe_t[i] - 1) && (obs_fe_t[i] <= exp_fe_t[i] + 1)), 64'd1);
      end
      chk({tag, "_pv_count"}, 64'(obs_pv_d.size()), 64'(exp_pv_d.size()));
      for (int i = 0; i < obs_pv_d.size() && i < exp_pv_d.size(); i++) begin
         chk({tag, "_period"}, 64'(obs_pv_d[i]), 64'(exp_pv_d[i]));
      end
      chk({tag, "_data_out_hold"}, 64'(data_out), 64'(last_good));
      chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
      obs_dv_t.delete(); obs_dv_d.delete(); obs_fe_t.delete(); obs_pv_d.delete();
      exp_dv_t.delete(); exp_dv_d.delete(); exp_fe_t.delete(); exp_pv_d.delete();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_data_out"}, 64'(data_out), 64'd0);
      chk({tag, "_data_valid"}, 64'(data_valid), 64'd0);
      chk({tag, "_frame_err"}, 64'(frame_err), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_period_out"}, 64'(period_out), 64'd0);
      chk({tag, "_period_valid"}, 64'(period_valid), 64'd0);
   endtask

   initial begin
      logic [7:0] pat;
      bit         bad;
      int         gap;

      reset_n   = 1'b0;
      signal_in = 1'b0;
      repeat (5) @(negedge clk);
      chk_reset_outputs("reset");
      reset_n = 1'b1;
      repeat (20) @(negedge clk);

      repeat (3) send_frame(8'hED, 1'b0, 1000 - (W + 2) * T2);
      check_events("ed_t1000");

      send_frame(8'hA5, 1'b1, 40);
      check_events("a5_stop_high");

      note_start();
      signal_in = 1'b1;
      repeat (3) @(negedge clk);
      signal_in = 1'b0;
      repeat (5) @(negedge clk);
      chk("glitch_busy_high", 64'(busy), 64'd1);
      repeat (20) @(negedge clk);
      chk("glitch_busy_drop", 64'(busy), 64'd0);
      send_frame(8'h5A, 1'b0, 40);
      check_events("glitch_then_5a");

      signal_in = 1'b1;
      repeat (30) @(negedge clk);
      chk("mid_data_busy", 64'(busy), 64'd1);
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("mid_rst");
      signal_in  = 1'b0;
      reset_n    = 1'b1;
      last_good  = 8'h00;
      have_first = 1'b0;
      repeat (5) @(negedge clk);
      send_frame(8'h81, 1'b0, 40);
      check_events("after_rst_81");

      send_frame(8'hFF, 1'b0, 0);
      send_frame(8'h00, 1'b0, 40);
      check_events("back_to_back");

      for (int k = 0; k < 10; k++) begin
         pat = 8'($urandom);
         bad = ($urandom_range(0, 3) == 0);
         gap = bad ? int'($urandom_range(2, 60)) : int'($urandom_range(0, 60));
         send_frame(pat, bad, gap);
      end
      check_events("random");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pulse_pattern_receiver.md
Name: pulse_pattern_receiver

Overview:
- Receive end of the serial pattern link driven by signal_generator.
- Recovers the WIDTH-bit pattern from a single-wire serial input.
- Flags framing errors, and optionally measures the frame repetition period.
- Sits on the FPGA input side and feeds pattern checkers and counters downstream.

Parameters:
- WIDTH, 8, pattern bits per frame.
- T2, 9, clock cycles per bit time; must be >= 2.
- CNT_W, 32, width of the period counter and period_out.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- signal_in  input  1  asynchronous serial line. Idles low.
- data_out  output  WIDTH  last correctly framed pattern, MSB = first data bit received.
- data_valid  output  1  one-cycle pulse when data_out updates.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled high.
- busy  output  1  high in every state except IDLE.
- period_out  output  CNT_W  start-to-start cycle count; present only with PERIOD_MEAS_EN.
- period_valid  output  1  one-cycle pulse when period_out updates; present only with PERIOD_MEAS_EN.

Behaviour:
- Frame format, all bits T2 cycles long:
  - start bit (1)
  - WIDTH data bits, MSB first
  - stop bit (0)
  - idle low, of any length.
- Input path:
  - signal_in passes through a 2-flop synchronizer; the synchronized value is s.
  - rise = s & ~s_d, registered.
- Mid-bit sample point: bit counter == T2/2, using floor (4 for T2=9).
- FSM states and transitions:
  - IDLE: on rise, clear the bit counter and go to START.
  - START: at the sample point, go to DATA if s==1. If s==0 it is a glitch: go to IDLE with no output.
  - DATA: sample s at each bit midpoint into the shift register. After WIDTH samples, go to STOP.
  - STOP: at the stop-bit midpoint, branch on s:
    - s==0: data_out <= shift register, pulse data_valid in the next cycle, go to IDLE.
    - s==1: pulse frame_err, leave data_out unchanged, go to IDLE.
- Returning to IDLE at the stop midpoint is deliberate: it allows a next start edge arriving half a bit later to be caught.
- Latency: data_valid rises 2 + 1 + (1 + WIDTH)*T2 + T2/2 + 1 cycles after the signal_in rising edge. This is 2+1+81+4+1 = 89 for the defaults; the bench checks against the RTL-derived constant with ±1 tolerance.
- rise events outside IDLE are ignored.
- Reset values: all outputs 0, FSM IDLE, shift register 0, period counter 0, the "first edge seen" flag cleared.
- Reset mid-frame aborts the frame immediately; no pulse is emitted.
- data_valid and frame_err are mutually exclusive and never assert in the same cycle.

Optional Feature:
- Macro: PULSE_RX_PERIOD_MEAS_EN.
- When defined:
  - A CNT_W counter increments every cycle and saturates at all-ones.
  - On each rise accepted in IDLE: if the first-edge flag is set, period_out <= counter + 1 and period_valid pulses. Then the counter resets to 0 and the flag is set.
  - The first frame after reset gives no period_valid.
  - A glitch start still restarts the count.
- When undefined:
  - period_out and period_valid are tied to 0.
  - No counter logic is synthesized.

Decomposition:
- Package pulse_rx_pkg holds:
  - state enum (IDLE, START, DATA, STOP)
  - T2 sample-point constant function
  - default WIDTH/T2 localparams shared with signal_generator.
- Sub-module: pulse_rx_sync, the 2-flop synchronizer plus edge detector.

Test Plan:
- Frames carrying N=8'hED, start-to-start spacing T1=1000 cycles, T2=9 → data_out=8'hED with data_valid every 1000 cycles. With the macro, period_out=1000 from the second frame on, and no period_valid on the first.
- 3-cycle high glitch while idle → START aborts, returns to IDLE, busy drops, no data_valid or frame_err. The next valid frame of 8'h5A is received correctly.
- Frame 8'hA5 with the stop bit held high → frame_err pulse only, data_out keeps its previous value 8'hED.
- reset_n low for 3 cycles mid-DATA → outputs 0 and busy 0. The following frame 8'h81 is received correctly, and no period_valid occurs until a second frame.
- Back-to-back frames with zero idle (start immediately follows stop), patterns 8'hFF then 8'h00 → both received in order, and period_out = (WIDTH+2)*T2 = 90.
- Pulse exclusivity across all scenarios → data_valid never coincides with frame_err, and neither pulse lasts more than one cycle.
